// File: rtl/id_pipe.sv
// MIPS-subset decode stage with forwarding, load-use stall and a registered ID/EX payload.
// Optional BEQ/BNE/J decode with combinational branch resolution when ID_PIPE_BRANCH_EN is defined.
module id_pipe #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               inst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic                      rd_en1_o,
    output logic                      rd_en2_o,
    output logic [4:0]                rd_addr1_o,
    output logic [4:0]                rd_addr2_o,
    input  logic [DATA_W-1:0]         rd_data1_i,
    input  logic [DATA_W-1:0]         rd_data2_i,
    input  logic [FWD_N-1:0]          fwd_wreg_i,
    input  logic [5*FWD_N-1:0]        fwd_wd_i,
    input  logic [DATA_W*FWD_N-1:0]   fwd_wdata_i,
    input  logic                      flush_i,
`ifdef ID_PIPE_BRANCH_EN
    output logic                      br_taken_o,
    output logic [31:0]               br_target_o,
`endif
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [7:0]                aluop_o,
    output logic [2:0]                alusel_o,
    output logic [DATA_W-1:0]         reg1_o,
    output logic [DATA_W-1:0]         reg2_o,
    output logic [4:0]                wd_o,
    output logic                      wreg_o,
    output logic                      is_load_o,
    output logic                      inst_invalid_o,
    output logic [31:0]               pc_o
);
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [7:0] EXE_LW_OP    = 8'b1110_0011;
`ifdef ID_PIPE_BRANCH_EN
    localparam logic [7:0] EXE_J_OP     = 8'b0100_1111;
    localparam logic [7:0] EXE_BEQ_OP   = 8'b0101_0001;
    localparam logic [7:0] EXE_BNE_OP   = 8'b0101_0010;
    localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;
`endif

    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
    localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    assign opcode = inst_i[31:26];
    assign funct  = inst_i[5:0];
    assign imm    = inst_i[15:0];

    // Unpacked views of the forwarding buses.
    logic [4:0]        fwd_wd_a   [FWD_N];
    logic [DATA_W-1:0] fwd_data_a [FWD_N];
    generate
        for (genvar gi = 0; gi < FWD_N; gi++) begin : g_fwd
            assign fwd_wd_a[gi]   = fwd_wd_i[gi*5 +: 5];
            assign fwd_data_a[gi] = fwd_wdata_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic [4:0]        dec_wd;
    logic              dec_wreg;
    logic              dec_invalid;
    logic              dec_load;
    logic              dec_en1;
    logic              dec_en2;
    logic              dec_r1_rt;
    logic              dec_r2_imm;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_beq;
    logic              dec_bne;
    logic              dec_j;

    always_comb begin
        dec_aluop   = EXE_NOP_OP;
        dec_alusel  = EXE_RES_NOP;
        dec_wd      = inst_i[20:16];
        dec_wreg    = 1'b0;
        dec_invalid = 1'b1;
        dec_load    = 1'b0;
        dec_en1     = 1'b0;
        dec_en2     = 1'b0;
        dec_r1_rt   = 1'b0;
        dec_r2_imm  = 1'b0;
        dec_imm     = '0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        dec_j       = 1'b0;
        case (opcode)
            6'b001101, 6'b001100, 6'b001110: begin
                dec_aluop   = (opcode == 6'b001101) ? EXE_OR_OP :
                              (opcode == 6'b001100) ? EXE_AND_OP : EXE_XOR_OP;
                dec_alusel  = EXE_RES_LOGIC;
                dec_wreg    = 1'b1;
                dec_invalid = 1'b0;
                dec_en1     = 1'b1;
                dec_r2_imm  = 1'b1;
                dec_imm     = DATA_W'(imm);
            end
            6'b001111: begin
                dec_aluop   = EXE_OR_OP;
                dec_alusel  = EXE_RES_LOGIC;
                dec_wreg    = 1'b1;
                dec_invalid = 1'b0;
                dec_en1     = 1'b1;
                dec_r2_imm  = 1'b1;
                dec_imm     = DATA_W'($signed({imm, 16'h0000}));
            end
            6'b001001, 6'b100011: begin
                dec_aluop   = (opcode == 6'b001001) ? EXE_ADDIU_OP : EXE_LW_OP;
                dec_alusel  = (opcode == 6'b001001) ? EXE_RES_ARITHMETIC : EXE_RES_LOAD_STORE;
                dec_load    = (opcode == 6'b100011);
                dec_wreg    = 1'b1;
                dec_invalid = 1'b0;
                dec_en1     = 1'b1;
                dec_r2_imm  = 1'b1;
                dec_imm     = DATA_W'($signed(imm));
            end
            6'b000000: begin
                dec_wd = inst_i[15:11];
                case (funct)
                    6'b100100: begin dec_aluop = EXE_AND_OP;  dec_alusel = EXE_RES_LOGIC;      end
                    6'b100101: begin dec_aluop = EXE_OR_OP;   dec_alusel = EXE_RES_LOGIC;      end
                    6'b100110: begin dec_aluop = EXE_XOR_OP;  dec_alusel = EXE_RES_LOGIC;      end
                    6'b100111: begin dec_aluop = EXE_NOR_OP;  dec_alusel = EXE_RES_LOGIC;      end
                    6'b100001: begin dec_aluop = EXE_ADDU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
                    6'b100011: begin dec_aluop = EXE_SUBU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
                    6'b000000: begin dec_aluop = EXE_SLL_OP;  dec_alusel = EXE_RES_SHIFT;      end
                    6'b000010: begin dec_aluop = EXE_SRL_OP;  dec_alusel = EXE_RES_SHIFT;      end
                    6'b000011: begin dec_aluop = EXE_SRA_OP;  dec_alusel = EXE_RES_SHIFT;      end
                    default:   begin dec_aluop = EXE_NOP_OP;  dec_alusel = EXE_RES_NOP;        end
                endcase
                dec_invalid = (dec_alusel == EXE_RES_NOP);
                dec_wreg    = !dec_invalid;
                // Shifts take rt through read port 2 and the shift amount as operand 2.
                if (dec_alusel == EXE_RES_SHIFT) begin
                    dec_en2    = 1'b1;
                    dec_r1_rt  = 1'b1;
                    dec_r2_imm = 1'b1;
                    dec_imm    = DATA_W'(inst_i[10:6]);
                end else if (!dec_invalid) begin
                    dec_en1 = 1'b1;
                    dec_en2 = 1'b1;
                end
            end
`ifdef ID_PIPE_BRANCH_EN
            6'b000100, 6'b000101: begin
                dec_aluop   = (opcode == 6'b000100) ? EXE_BEQ_OP : EXE_BNE_OP;
                dec_alusel  = EXE_RES_JUMP_BRANCH;
                dec_invalid = 1'b0;
                dec_en1     = 1'b1;
                dec_en2     = 1'b1;
                dec_beq     = (opcode == 6'b000100);
                dec_bne     = (opcode == 6'b000101);
            end
            6'b000010: begin
                dec_aluop   = EXE_J_OP;
                dec_alusel  = EXE_RES_JUMP_BRANCH;
                dec_invalid = 1'b0;
                dec_j       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign rd_en1_o   = in_valid_i & dec_en1;
    assign rd_en2_o   = in_valid_i & dec_en2;
    assign rd_addr1_o = inst_i[25:21];
    assign rd_addr2_o = inst_i[20:16];

    // Walk oldest to youngest so the lowest matching index overrides.
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    always_comb begin
        op1 = rd_data1_i;
        for (int i = FWD_N - 1; i >= 0; i--) begin
            if (fwd_wreg_i[i] && fwd_wd_a[i] == rd_addr1_o) op1 = fwd_data_a[i];
        end
        if (rd_addr1_o == 5'd0) op1 = '0;
    end

    always_comb begin
        op2 = rd_data2_i;
        for (int i = FWD_N - 1; i >= 0; i--) begin
            if (fwd_wreg_i[i] && fwd_wd_a[i] == rd_addr2_o) op2 = fwd_data_a[i];
        end
        if (rd_addr2_o == 5'd0) op2 = '0;
    end

    logic [DATA_W-1:0] dec_reg1;
    logic [DATA_W-1:0] dec_reg2;
    assign dec_reg1 = dec_r1_rt  ? op2 : op1;
    assign dec_reg2 = dec_r2_imm ? dec_imm : op2;

    logic              out_valid_reg;
    logic [7:0]        aluop_reg;
    logic [2:0]        alusel_reg;
    logic [DATA_W-1:0] reg1_reg;
    logic [DATA_W-1:0] reg2_reg;
    logic [4:0]        wd_reg;
    logic              wreg_reg;
    logic              is_load_reg;
    logic              inst_invalid_reg;
    logic [31:0]       pc_reg;

    logic advance;
    logic hazard;
    logic accept;
    assign advance = out_ready_i | ~out_valid_reg;
    assign hazard  = out_valid_reg & is_load_reg & (wd_reg != 5'd0) &
                     ((rd_en1_o & (wd_reg == rd_addr1_o)) | (rd_en2_o & (wd_reg == rd_addr2_o)));
    assign in_ready_o = rst ? 1'b0 : (flush_i ? 1'b1 : (advance & ~hazard));
    assign accept     = in_valid_i & in_ready_o & ~flush_i;

`ifdef ID_PIPE_BRANCH_EN
    logic [31:0] pc_plus4;
    assign pc_plus4    = pc_i + 32'd4;
    assign br_taken_o  = accept & (dec_j | (dec_beq & (op1 == op2)) | (dec_bne & (op1 != op2)));
    assign br_target_o = dec_j ? {pc_plus4[31:28], inst_i[25:0], 2'b00}
                               : pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
`else
    logic unused_dec;
    assign unused_dec = dec_beq | dec_bne | dec_j;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            aluop_reg        <= EXE_NOP_OP;
            alusel_reg       <= EXE_RES_NOP;
            reg1_reg         <= '0;
            reg2_reg         <= '0;
            wd_reg           <= '0;
            wreg_reg         <= 1'b0;
            is_load_reg      <= 1'b0;
            inst_invalid_reg <= 1'b0;
            pc_reg           <= '0;
        end else if (flush_i || (advance && !accept)) begin
            // Flush and bubble load the same harmless payload; data fields hold.
            out_valid_reg    <= 1'b0;
            aluop_reg        <= EXE_NOP_OP;
            alusel_reg       <= EXE_RES_NOP;
            wreg_reg         <= 1'b0;
            is_load_reg      <= 1'b0;
            inst_invalid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg    <= 1'b1;
            aluop_reg        <= dec_aluop;
            alusel_reg       <= dec_alusel;
            reg1_reg         <= dec_reg1;
            reg2_reg         <= dec_reg2;
            wd_reg           <= dec_wd;
            wreg_reg         <= dec_wreg;
            is_load_reg      <= dec_load;
            inst_invalid_reg <= dec_invalid;
            pc_reg           <= pc_i;
        end
    end

    assign out_valid_o    = out_valid_reg;
    assign aluop_o        = aluop_reg;
    assign alusel_o       = alusel_reg;
    assign reg1_o         = reg1_reg;
    assign reg2_o         = reg2_reg;
    assign wd_o           = wd_reg;
    assign wreg_o         = wreg_reg;
    assign is_load_o      = is_load_reg;
    assign inst_invalid_o = inst_invalid_reg;
    assign pc_o           = pc_reg;
endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter DATA_W, 32, operand/result width (32 or 64); immediates extend to DATA_W.
REQ-002 Parameter FWD_N, 2, forwarding source count; index 0 is youngest (EX), highest index oldest.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pc_i, inst_i  in  32 each  fetched PC and instruction; in_valid_i in 1; in_ready_o out 1.
REQ-006 rd_en1_o, rd_en2_o  out  1; rd_addr1_o, rd_addr2_o  out  5  combinational regfile read requests.
REQ-007 rd_data1_i, rd_data2_i  in  DATA_W  regfile read data, same cycle.
REQ-008 fwd_wreg_i  in  FWD_N; fwd_wd_i  in  5*FWD_N; fwd_wdata_i  in  DATA_W*FWD_N  packed forwarding sources.
REQ-009 flush_i  in  1  discard the registered instruction and the current input.
REQ-010 out_valid_o out 1; out_ready_i in 1  ID/EX handshake.
REQ-011 aluop_o out 8, alusel_o out 3, reg1_o/reg2_o out DATA_W, wd_o out 5, wreg_o out 1, is_load_o out 1, inst_invalid_o out 1, pc_o out 32: registered ID/EX payload.

Function
REQ-012 Decode shall cover ORI, ANDI, XORI, LUI, ADDIU, LW and SPECIAL AND, OR, XOR, NOR, ADDU, SUBU, SLL, SRL, SRA, using the team EXE_*_OP / EXE_RES_* encodings.
REQ-013 Logic immediates shall zero-extend; ADDIU/LW offsets shall sign-extend; LUI yields imm<<16 then sign-extends to DATA_W.
REQ-014 Immediate forms: reg1_o = rs operand, reg2_o = immediate, wd_o = rt; R-forms: wd_o = rd; shifts: reg1_o = rt operand, reg2_o = zero-extended sa.
REQ-015 Operand select per read port: lowest-index fwd entry with wreg=1 and wd equal to read address wins, else regfile data; address 0 always yields 0 and is never forwarded.
REQ-016 Unknown opcode/funct: aluop NOP, wreg_o=0, inst_invalid_o=1, out_valid_o=1.
REQ-017 advance = out_ready_i | ~out_valid_o; payload register updates only when advance.
REQ-018 Load-use hazard = out_valid_o & is_load_o & wd_o!=0 & ((rd_en1_o & wd_o==rd_addr1_o) | (rd_en2_o & wd_o==rd_addr2_o)).
REQ-019 in_ready_o = advance & ~hazard; with flush_i=1, in_ready_o=1.
REQ-020 On advance: accepted input loads decoded payload with out_valid_o=1; otherwise a bubble loads (out_valid_o=0, wreg_o=0, aluop NOP).
REQ-021 Hazard shall cost exactly one bubble; the dependent instruction is accepted the next cycle if downstream is ready.
REQ-022 flush_i shall clear out_valid_o and wreg_o next cycle and drop the input; priority rst > flush_i > advance.
REQ-023 With out_ready_i=0 and out_valid_o=1, all payload outputs shall hold stable.
REQ-024 Decode-to-output latency is one cycle; back-to-back throughput is one per cycle absent hazards.

Reset
REQ-025 On rst: out_valid_o=0, wreg_o=0, is_load_o=0, inst_invalid_o=0, aluop NOP, alusel NOP, reg1_o=reg2_o=0, wd_o=0, pc_o=0.
REQ-026 During rst in_ready_o=0; reset mid-stall discards the stalled input and the pending hazard.

Configuration
REQ-027 Macro ID_PIPE_BRANCH_EN defined: BEQ, BNE, J decoded; outputs br_taken_o (1) and br_target_o (32) combinational, valid when in_valid_i & in_ready_o.
REQ-028 BEQ/BNE compare forwarded operands, target = pc+4+(sext(imm)<<2); J target = {pc+4[31:28], index, 2'b00}; branches write no register and are subject to load-use stall.
REQ-029 Macro undefined: br_* ports absent; BEQ, BNE, J decode as invalid per REQ-016.

Verification
REQ-030 ORI $1,$0,0x8000 -> next cycle reg1_o=0, reg2_o=0x00008000, wd_o=1, wreg_o=1, aluop OR.
REQ-031 ADDU $3,$1,$2 with fwd0 {wd=1,data=5} and fwd1 {wd=1,data=9} -> reg1_o=5 (youngest wins).
REQ-032 LW $4,0($1) then ORI $5,$4,1 -> one bubble (out_valid_o=0 one cycle), then ORI issues with fwd1 value.
REQ-033 out_ready_i=0 for 3 cycles with valid payload -> in_ready_o=0, payload unchanged; release -> next instruction in one cycle.
REQ-034 flush_i during load-use stall -> out_valid_o=0 next cycle, stalled input dropped; rst mid-stream -> all outputs per REQ-025.
REQ-035 ID_PIPE_BRANCH_EN, BEQ $1,$1,-1 at pc 0x100 -> br_taken_o=1, br_target_o=0x100.
